interfaz_uart_periferico: RTL

- Memory-mapped UART peripheral that sits directly downstream of the processor write-enable demux.
- Consumes one per-UART write strobe (we_uart_a/b/c) plus the low address bits and store data.
- Exposes three 32-bit registers: control at +0x0, TX data at +0x8, RX data at +0xC. For UART A these are 0x2010, 0x2018 and 0x201C.
- Contains the 8N1 serializer/deserializer. Instantiated three times (A, B, C) in the bus/IO top.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_nucleo.sv | 99 +++++++++
 rtl/interfaz_uart_periferico.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: FSM states, register
// word offsets and control-register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_st_e;

    localparam logic [1:0] REG_CTRL = 2'b00;
    localparam logic [1:0] REG_TXD  = 2'b10;
    localparam logic [1:0] REG_RXD  = 2'b11;

    localparam int CTRL_SEND   = 0;
    localparam int CTRL_NEW_RX = 1;
    localparam int CTRL_FERR   = 2;
    localparam int CTRL_OVR    = 3;

endpackage

// File: rtl/uart_rx_nucleo.sv
// 8N1 receiver core: two-flop synchronizer, start-bit qualification at
// half a bit time, mid-bit sampling of 8 data bits (LSB first) and stop
// bit check. Emits one-cycle valid or frame_err pulses.
module uart_rx_nucleo
    import uart_pkg::*;
#(
    parameter int DIV = 86
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);

    logic             r_sync1;
    logic             r_sync2;
    uart_st_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;
    logic             w_rx_s;

    assign w_rx_s      = r_sync2;
    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM with baud counter, bit index and LSB-first shifter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // A line back high at mid start bit was only a glitch.
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (w_rx_s) r_valid <= 1'b1;
                        else        r_ferr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/interfaz_uart_periferico.sv
// Memory-mapped UART peripheral: control / TX data / RX data registers,
// 8N1 transmitter and an instance of the receiver core.
module interfaz_uart_periferico
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 115200,
    parameter int DIV      = CLK_FREQ / BAUD
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    uart_st_e         r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic             r_tx;
    logic             r_send;
    logic [7:0]       r_txd;
    logic [7:0]       r_rxd;
    logic             r_new_rx;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_wr_ctrl;
    logic             w_wr_txd;
    logic [7:0]       w_rx_byte;
    logic             w_rx_valid;
    logic             w_rx_ferr;
    logic             w_unused;

    assign w_wr_ctrl = we_i && (addr_i == REG_CTRL);
    assign w_wr_txd  = we_i && (addr_i == REG_TXD);
    assign w_unused  = ^wdata_i[31:8];
    assign tx_o      = r_tx;

    uart_rx_nucleo #(
        .DIV (DIV)
    ) u_rx (
        .i_clk       (clk_i),
        .i_rst_n     (rst_n_i),
        .i_rx        (rx_i),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr)
    );

    // Transmit FSM: start, 8 data bits LSB first, stop; each DIV cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
            r_send     <= 1'b0;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_wr_ctrl && wdata_i[CTRL_SEND]) begin
                        r_tx_state <= ST_START;
                        r_tx       <= 1'b0;
                        r_send     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= ST_DATA;
                        r_tx       <= r_txd[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= ST_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            r_tx     <= r_txd[r_tx_bit + 3'd1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_IDLE;
                        r_send     <= 1'b0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // Register file: TX data (locked while sending), RX data and status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_txd    <= '0;
            r_rxd    <= '0;
            r_new_rx <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_wr_txd && (r_tx_state == ST_IDLE)) r_txd <= wdata_i[7:0];
            // Software clears first so a same-cycle hardware set overrides them.
            if (w_wr_ctrl) begin
                if (!wdata_i[CTRL_NEW_RX]) r_new_rx <= 1'b0;
                if (!wdata_i[CTRL_FERR])   r_ferr   <= 1'b0;
                if (!wdata_i[CTRL_OVR])    r_ovr    <= 1'b0;
            end
            if (w_rx_valid) begin
                r_rxd    <= w_rx_byte;
                r_new_rx <= 1'b1;
                if (r_new_rx) r_ovr <= 1'b1;
            end
            if (w_rx_ferr) r_ferr <= 1'b1;
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata_o = '0;
        case (addr_i)
            REG_CTRL: rdata_o = {28'd0, r_ovr, r_ferr, r_new_rx, r_send};
            REG_TXD:  rdata_o = {24'd0, r_txd};
            REG_RXD:  rdata_o = {24'd0, r_rxd};
            default:  rdata_o = '0;
        endcase
    end

endmodule
